// File: rtl/fib_rec_ctrl.sv
`timescale 1ns/1ps
// fib_rec_ctrl: computes fib(n) by real recursion on an external 3-bit return-code stack.
// The result is the number of fib(1) leaves reached; the stack only ever holds return codes.
// Optional build macro: FIB_CYC_CNT_EN adds the cyc_cnt busy-cycle counter port.
//
// state | meaning
// IDLE  | waiting for start; done/err/result hold the last job's outcome
// DRN   | pop one stale entry off the stack
// DRNW  | wait for the pop to land; loop back until the stack reports empty
// CHK   | call entry: leaf (n<2) counts and returns, else push RET1 and recurse on n-1
// POP   | return: pop the caller's return code
// POPW  | dispatch on the popped code (empty stack means the top-level call returned)
// DONE  | publish acc as result, drop busy
module fib_rec_ctrl #(
   parameter int N_W   = 5,
   parameter int MAX_N = 31,
   parameter int RES_W = 21
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [N_W-1:0]   n_in,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [RES_W-1:0] result,
   output logic             stk_push,
   output logic             stk_pop,
   output logic [2:0]       stk_din,
   input  logic [2:0]       stk_dout,
   input  logic             stk_empty
`ifdef FIB_CYC_CNT_EN
   ,
   output logic [31:0]      cyc_cnt
`endif
);

   localparam logic [2:0] RET1 = 3'd1;
   localparam logic [2:0] RET2 = 3'd2;

   // n is one bit wider than n_in so the n+2 restore and the >MAX_N compare never wrap
   localparam logic [N_W:0] MAX_N_V = (N_W+1)'(MAX_N);
   localparam logic [N_W:0] N_ONE   = (N_W+1)'(1);
   localparam logic [N_W:0] N_TWO   = (N_W+1)'(2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DRN,
      S_DRNW,
      S_CHK,
      S_POP,
      S_POPW,
      S_DONE
   } state_t;

   state_t           state, state_nxt;
   logic [N_W:0]     n, n_nxt;
   logic [RES_W-1:0] acc, acc_nxt;
   logic             busy_nxt, done_nxt, err_nxt;
   logic [RES_W-1:0] result_nxt;
   logic [N_W:0]     n_in_ext;
   logic [RES_W-1:0] leaf_inc;
   logic             start_ok;

   assign n_in_ext = {1'b0, n_in};
   assign leaf_inc = {{(RES_W-1){1'b0}}, (n == N_ONE)};
   assign start_ok = (state == S_IDLE) && start && !busy;

   // State and datapath registers; async reset puts every output at its idle value at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         n      <= '0;
         acc    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         result <= '0;
      end else begin
         state  <= state_nxt;
         n      <= n_nxt;
         acc    <= acc_nxt;
         busy   <= busy_nxt;
         done   <= done_nxt;
         err    <= err_nxt;
         result <= result_nxt;
      end
   end

   // Next-state, datapath update and stack strobes
   always_comb begin
      state_nxt  = state;
      n_nxt      = n;
      acc_nxt    = acc;
      busy_nxt   = busy;
      done_nxt   = done;
      err_nxt    = err;
      result_nxt = result;
      stk_push   = 1'b0;
      stk_pop    = 1'b0;
      stk_din    = 3'd0;
      case (state)
         S_IDLE: begin
            if (start_ok) begin
               if (n_in_ext > MAX_N_V) begin
                  // rejected without touching the stack
                  done_nxt   = 1'b1;
                  err_nxt    = 1'b1;
                  result_nxt = '0;
               end else begin
                  n_nxt     = n_in_ext;
                  acc_nxt   = '0;
                  done_nxt  = 1'b0;
                  err_nxt   = 1'b0;
                  busy_nxt  = 1'b1;
                  state_nxt = S_DRN;
               end
            end
         end
         S_DRN: begin
            stk_pop   = 1'b1;
            state_nxt = S_DRNW;
         end
         S_DRNW: begin
            state_nxt = stk_empty ? S_CHK : S_DRN;
         end
         S_CHK: begin
            if (n < N_TWO) begin
               acc_nxt   = acc + leaf_inc;
               state_nxt = S_POP;
            end else begin
               stk_push = 1'b1;
               stk_din  = RET1;
               n_nxt    = n - N_ONE;
            end
         end
         S_POP: begin
            stk_pop   = 1'b1;
            state_nxt = S_POPW;
         end
         S_POPW: begin
            if (stk_empty) begin
               state_nxt = S_DONE;
            end else begin
               case (stk_dout)
                  RET1: begin
                     // first child returned with n = parent-1; call second child on parent-2
                     stk_push  = 1'b1;
                     stk_din   = RET2;
                     n_nxt     = n - N_ONE;
                     state_nxt = S_CHK;
                  end
                  RET2: begin
                     // second child returned with n = parent-2; restore and return
                     n_nxt     = n + N_TWO;
                     state_nxt = S_POP;
                  end
                  default: begin
                     err_nxt   = 1'b1;
                     state_nxt = S_DONE;
                  end
               endcase
            end
         end
         S_DONE: begin
            result_nxt = acc;
            done_nxt   = 1'b1;
            busy_nxt   = 1'b0;
            state_nxt  = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef FIB_CYC_CNT_EN
   // Busy-cycle counter: restarts on each accepted start, freezes once the job is done
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cyc_cnt <= '0;
      end else if (start_ok) begin
         cyc_cnt <= '0;
      end else if (busy) begin
         cyc_cnt <= cyc_cnt + 32'd1;
      end
   end
`endif

endmodule
